// File: rtl/cpu_pkg.sv
// Shared definitions for the parametrised control unit: FSM state encodings,
// opcode map and ALU operation codes.
package cpu_pkg;

    localparam int DEF_REG_ADDR_W = 3;

    localparam logic [3:0] OP_MV   = 4'h0;
    localparam logic [3:0] OP_MVI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_LD   = 4'h4;
    localparam logic [3:0] OP_ST   = 4'h5;
    localparam logic [3:0] OP_MVNZ = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_MVZ  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;

    typedef enum logic [4:0] {
        S_IDLE    = 5'd0,
        S_LD_ADDR = 5'd1,
        S_PC_INC  = 5'd2,
        S_FETCH   = 5'd3,
        S_DECODE  = 5'd4,
        S_MV      = 5'd5,
        S_MVI1    = 5'd6,
        S_MVI2    = 5'd7,
        S_ALU1    = 5'd8,
        S_ALU2    = 5'd9,
        S_ALU3    = 5'd10,
        S_LD1     = 5'd11,
        S_LD2     = 5'd12,
        S_ST1     = 5'd13,
        S_ST2     = 5'd14,
        S_ST3     = 5'd15,
        S_SKIP    = 5'd16,
        S_HALTED  = 5'd17
    } state_t;

    function automatic logic [1:0] alu_op_of(input logic [3:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/reg_decoder.sv
// Binary register index to one-hot select, used for the rX and rY fields.
module reg_decoder #(
    parameter int N = 3
) (
    input  logic [N-1:0]    i_sel,
    output logic [2**N-1:0] o_onehot
);

    always_comb begin
        o_onehot        = '0;
        o_onehot[i_sel] = 1'b1;
    end

endmodule

// File: rtl/control_unit_param.sv
// Multi-cycle control unit: fetches {opcode, rX, rY} over a wait-stated memory
// port and sequences the shared-bus datapath strobes for each instruction.
module control_unit_param
    import cpu_pkg::*;
#(
    parameter int  DATA_W     = 16,
    parameter int  REG_ADDR_W = DEF_REG_ADDR_W,
    localparam int IR_W       = 4 + 2*REG_ADDR_W,
    localparam int NREGS      = 2**REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [DATA_W-1:0] din,
    input  logic              mem_ready,
    input  logic              g_zero,
    output logic [IR_W-1:0]   ir,
    output logic [4:0]        state,
    output logic [NREGS-1:0]  r_in,
    output logic [NREGS-1:0]  r_out,
    output logic              g_out,
    output logic              din_out,
    output logic              a_in,
    output logic              g_in,
    output logic [1:0]        alu_op,
    output logic              addr_in,
    output logic              dout_in,
    output logic              w_d,
    output logic              incr_pc,
    output logic              done,
    output logic              halted,
    output logic              illegal
);

    localparam logic [NREGS-1:0] PC_OH = {1'b1, {(NREGS-1){1'b0}}};

    state_t                r_state;
    logic [IR_W-1:0]       r_ir;
    logic                  r_illegal;

    logic [3:0]            w_opcode;
    logic [REG_ADDR_W-1:0] w_rx;
    logic [REG_ADDR_W-1:0] w_ry;
    logic [NREGS-1:0]      w_x_oh;
    logic [NREGS-1:0]      w_y_oh;
    logic                  w_x_is_pc;
    state_t                w_after_done;
    logic                  w_unused_din;

    assign w_opcode     = r_ir[IR_W-1 -: 4];
    assign w_rx         = r_ir[2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign w_ry         = r_ir[REG_ADDR_W-1:0];
    assign w_x_is_pc    = &w_rx;
    assign w_after_done = run ? S_LD_ADDR : S_IDLE;
    assign w_unused_din = ^din;

    reg_decoder #(.N(REG_ADDR_W)) u_dec_x (.i_sel(w_rx), .o_onehot(w_x_oh));
    reg_decoder #(.N(REG_ADDR_W)) u_dec_y (.i_sel(w_ry), .o_onehot(w_y_oh));

    // NOTE: reset is sampled on the clock edge, so a wait state is abandoned
    // on the very next edge; all state updates are non-blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ir      <= '0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE:    if (run) r_state <= S_LD_ADDR;
                S_LD_ADDR: r_state <= S_PC_INC;
                S_PC_INC:  r_state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir    <= din[IR_W-1:0];
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (w_opcode)
                        OP_MV:                  r_state <= S_MV;
                        OP_MVI:                 r_state <= S_MVI1;
                        OP_ADD, OP_SUB, OP_AND: r_state <= S_ALU1;
                        OP_LD:                  r_state <= S_LD1;
                        OP_ST:                  r_state <= S_ST1;
                        OP_MVNZ:                r_state <= g_zero ? S_SKIP : S_MV;
                        OP_MVZ:                 r_state <= g_zero ? S_MV : S_SKIP;
                        OP_HALT:                r_state <= S_HALTED;
                        default: begin
                            r_state   <= S_HALTED;
                            r_illegal <= 1'b1;
                        end
                    endcase
                end
                S_MV, S_ALU3, S_SKIP: r_state <= w_after_done;
                S_MVI1:    r_state <= S_MVI2;
                S_MVI2:    if (mem_ready) r_state <= w_after_done;
                S_ALU1:    r_state <= S_ALU2;
                S_ALU2:    r_state <= S_ALU3;
                S_LD1:     r_state <= S_LD2;
                S_LD2:     if (mem_ready) r_state <= w_after_done;
                S_ST1:     r_state <= S_ST2;
                S_ST2:     r_state <= S_ST3;
                S_ST3:     if (mem_ready) r_state <= w_after_done;
                S_HALTED:  r_state <= S_HALTED;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode straight from the current state so a ready memory
    // completes its access in the same cycle it reports ready.
    always_comb begin
        r_in    = '0;
        r_out   = '0;
        g_out   = 1'b0;
        din_out = 1'b0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        alu_op  = ALU_ADD;
        addr_in = 1'b0;
        dout_in = 1'b0;
        w_d     = 1'b0;
        incr_pc = 1'b0;
        done    = 1'b0;
        halted  = 1'b0;
        case (r_state)
            S_LD_ADDR: begin
                r_out   = PC_OH;
                addr_in = 1'b1;
            end
            S_PC_INC: incr_pc = 1'b1;
            S_MV: begin
                r_out = w_y_oh;
                r_in  = w_x_oh;
                done  = 1'b1;
            end
            S_MVI1: begin
                r_out   = PC_OH;
                addr_in = 1'b1;
            end
            S_MVI2: begin
                if (mem_ready) begin
                    din_out = 1'b1;
                    r_in    = w_x_oh;
                    done    = 1'b1;
                    incr_pc = !w_x_is_pc;
                end
            end
            S_ALU1: begin
                r_out = w_x_oh;
                a_in  = 1'b1;
            end
            S_ALU2: begin
                r_out  = w_y_oh;
                g_in   = 1'b1;
                alu_op = alu_op_of(w_opcode);
            end
            S_ALU3: begin
                g_out = 1'b1;
                r_in  = w_x_oh;
                done  = 1'b1;
            end
            S_LD1: begin
                r_out   = w_y_oh;
                addr_in = 1'b1;
            end
            S_LD2: begin
                if (mem_ready) begin
                    din_out = 1'b1;
                    r_in    = w_x_oh;
                    done    = 1'b1;
                end
            end
            S_ST1: begin
                r_out   = w_x_oh;
                dout_in = 1'b1;
            end
            S_ST2: begin
                r_out   = w_y_oh;
                addr_in = 1'b1;
            end
            S_ST3: begin
                w_d  = 1'b1;
                done = mem_ready;
            end
            S_SKIP:   done   = 1'b1;
            S_HALTED: halted = 1'b1;
            default: ;
        endcase
    end

    assign ir      = r_ir;
    assign state   = r_state;
    assign illegal = r_illegal;

endmodule
